// File: rtl/xmpl_flt_mac.sv
// Multi-channel signed multiply-accumulate filter: product register, per-channel
// accumulation of ACC_LEN products, optional saturation and a 2-entry result buffer.
module xmpl_flt_mac #(
    parameter int A_W     = 7,
    parameter int B_W     = 8,
    parameter int ACC_LEN = 256,
    parameter int NUM_CH  = 2,
    parameter int OUT_W   = A_W + B_W + $clog2(ACC_LEN),
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_flt_i,
    input  logic                    clr_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [CH_W-1:0]         in_ch_i,
    input  logic signed [A_W-1:0]   flt_a_i,
    input  logic signed [B_W-1:0]   flt_b_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CH_W-1:0]         out_ch_o,
    output logic signed [OUT_W-1:0] flt_c_o,
    output logic                    flt_status_o
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(ACC_LEN);
    localparam int ACC_W = P_W + CNT_W;
    localparam logic [CH_W:0]      NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic                    run_q, run_d;
    logic signed [P_W-1:0]   prod_q, prod_d;
    logic [CH_W-1:0]         s1_ch_q, s1_ch_d;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [ACC_W-1:0] acc_q [NUM_CH];
    logic signed [ACC_W-1:0] acc_d [NUM_CH];
    logic [CNT_W-1:0]        cnt_q [NUM_CH];
    logic [CNT_W-1:0]        cnt_d [NUM_CH];
    logic signed [OUT_W-1:0] buf_data_q [2];
    logic signed [OUT_W-1:0] buf_data_d [2];
    logic [CH_W-1:0]         buf_ch_q [2];
    logic [CH_W-1:0]         buf_ch_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              buf_cnt_q, buf_cnt_d;
    logic                    status_q, status_d;

    logic                    accept;
    logic                    ch_ok;
    logic                    pop;
    logic                    push;
    logic                    wr_ptr;
    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_hit;

    // run_q keeps in_ready_o low while reset is asserted and for the first edge after it.
    assign in_ready_o   = run_q && en_flt_i && !clr_i && ((buf_cnt_q + 2'(s1_valid_q)) < 2'd2);
    assign accept       = in_valid_i && in_ready_o;
    assign ch_ok        = ({1'b0, in_ch_i} < NUM_CH_L);
    assign pop          = (buf_cnt_q != 2'd0) && out_ready_i;
    assign wr_ptr       = rd_ptr_q ^ buf_cnt_q[0];
    assign a_ext        = P_W'(flt_a_i);
    assign b_ext        = P_W'(flt_b_i);
    assign prod_ext     = {{(ACC_W - P_W){prod_q[P_W-1]}}, prod_q};
    assign sum          = acc_q[s1_ch_q] + prod_ext;

    assign out_valid_o  = (buf_cnt_q != 2'd0);
    assign out_ch_o     = buf_ch_q[rd_ptr_q];
    assign flt_c_o      = buf_data_q[rd_ptr_q];
    assign flt_status_o = status_q;

    generate
        if (OUT_W < ACC_W) begin : g_sat
            always_comb begin
                sat_hit = (sum[ACC_W-1:OUT_W-1] != {(ACC_W - OUT_W + 1){sum[ACC_W-1]}});
                if (!sat_hit) begin
                    sat_val = sum[OUT_W-1:0];
                end else if (sum[ACC_W-1]) begin
                    sat_val = {1'b1, {(OUT_W - 1){1'b0}}};
                end else begin
                    sat_val = {1'b0, {(OUT_W - 1){1'b1}}};
                end
            end
        end else begin : g_ext
            assign sat_hit = 1'b0;
            assign sat_val = OUT_W'(sum);
        end
    endgenerate

    always_comb begin
        run_d      = 1'b1;
        prod_d     = prod_q;
        s1_ch_d    = s1_ch_q;
        s1_valid_d = accept && ch_ok;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        buf_data_d = buf_data_q;
        buf_ch_d   = buf_ch_q;
        rd_ptr_d   = rd_ptr_q;
        status_d   = status_q;
        push       = 1'b0;

        if (accept) begin
            prod_d  = a_ext * b_ext;
            s1_ch_d = in_ch_i;
        end

        // The sum comes straight from acc_q, so back-to-back beats on one channel chain correctly.
        if (s1_valid_q) begin
            if (cnt_q[s1_ch_q] == CNT_LAST) begin
                acc_d[s1_ch_q] = '0;
                cnt_d[s1_ch_q] = '0;
                push           = 1'b1;
            end else begin
                acc_d[s1_ch_q] = sum;
                cnt_d[s1_ch_q] = cnt_q[s1_ch_q] + 1'b1;
            end
        end

        // in_ready_o throttling guarantees the buffer is never full when push is set.
        if (push) begin
            buf_data_d[wr_ptr] = sat_val;
            buf_ch_d[wr_ptr]   = s1_ch_q;
            status_d           = status_q | sat_hit;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        buf_cnt_d = buf_cnt_q + 2'(push) - 2'(pop);

        if (clr_i) begin
            prod_d     = '0;
            s1_ch_d    = '0;
            s1_valid_d = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
            for (int i = 0; i < 2; i++) begin
                buf_data_d[i] = '0;
                buf_ch_d[i]   = '0;
            end
            rd_ptr_d  = 1'b0;
            buf_cnt_d = 2'd0;
            status_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_q      <= 1'b0;
            prod_q     <= '0;
            s1_ch_q    <= '0;
            s1_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_ch_q[i]   <= '0;
            end
            rd_ptr_q  <= 1'b0;
            buf_cnt_q <= 2'd0;
            status_q  <= 1'b0;
        end else begin
            run_q      <= run_d;
            prod_q     <= prod_d;
            s1_ch_q    <= s1_ch_d;
            s1_valid_q <= s1_valid_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            buf_data_q <= buf_data_d;
            buf_ch_q   <= buf_ch_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_cnt_q  <= buf_cnt_d;
            status_q   <= status_d;
        end
    end

endmodule

// File: tb/tb_xmpl_flt_mac.sv
// Bench for xmpl_flt_mac: two instances (OUT_W=17 and OUT_W=12, ACC_LEN=4, NUM_CH=2)
// share one stimulus stream and are checked against a per-channel running-sum model.
module tb_xmpl_flt_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, en, clr, in_valid, out_ready;
    logic [0:0]        ch;
    logic signed [6:0] a;
    logic signed [7:0] b;

    logic               rdy17, vld17, st17;
    logic [0:0]         ch17;
    logic signed [16:0] c17;
    logic               rdy12, vld12, st12;
    logic [0:0]         ch12;
    logic signed [11:0] c12;

    xmpl_flt_mac #(.ACC_LEN(4), .NUM_CH(2), .OUT_W(17)) u_dut17 (
        .clk_i(clk), .reset_n_i(rst_n), .en_flt_i(en), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(rdy17), .in_ch_i(ch),
        .flt_a_i(a), .flt_b_i(b), .out_valid_o(vld17), .out_ready_i(out_ready),
        .out_ch_o(ch17), .flt_c_o(c17), .flt_status_o(st17));

    xmpl_flt_mac #(.ACC_LEN(4), .NUM_CH(2), .OUT_W(12)) u_dut12 (
        .clk_i(clk), .reset_n_i(rst_n), .en_flt_i(en), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(rdy12), .in_ch_i(ch),
        .flt_a_i(a), .flt_b_i(b), .out_valid_o(vld12), .out_ready_i(out_ready),
        .out_ch_o(ch12), .flt_c_o(c12), .flt_status_o(st12));

    typedef struct {
        int ch;
        int sum;
    } exp_t;

    exp_t exp_q[$];
    int   m_sum[2];
    int   m_cnt[2];
    bit   sat_all_or, sat_pop_or;
    int   n_tests, n_fail;
    bit   last_acc, last_vld, last_rdy, last_st12;
    int   acc_total;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
        end
        sat_all_or = 1'b0;
        sat_pop_or = 1'b0;
    endfunction

    function automatic void model_beat(input int c, input int pa, input int pb);
        exp_t e;
        m_sum[c] += pa * pb;
        m_cnt[c]++;
        if (m_cnt[c] == 4) begin
            e.ch  = c;
            e.sum = m_sum[c];
            exp_q.push_back(e);
            if (sat12(e.sum) != e.sum) sat_all_or = 1'b1;
            m_sum[c] = 0;
            m_cnt[c] = 0;
        end
    endfunction

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("spurious_out", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_val("out_ch17", int'(ch17), e.ch);
            check_val("out_ch12", int'(ch12), e.ch);
            check_val("out_c17", int'(c17), e.sum);
            check_val("out_c12", int'(c12), sat12(e.sum));
            check_val("status17", int'(st17), 0);
            if (sat12(e.sum) != e.sum) sat_pop_or = 1'b1;
            if (sat_pop_or == sat_all_or) check_val("status12", int'(st12), int'(sat_pop_or));
        end
    endtask

    // Inputs are changed at the falling edge; everything is sampled 1 unit before the rising edge.
    task automatic tick();
        bit acc, pop;
        #4;
        acc       = in_valid && rdy17;
        pop       = vld17 && out_ready;
        last_vld  = vld17;
        last_rdy  = rdy17;
        last_st12 = st12;
        if (rdy12 != rdy17 || vld12 != vld17) check_val("inst_hs_agree", int'({rdy12, vld12}), int'({rdy17, vld17}));
        if (pop) check_pop();
        if (!rst_n || clr) model_clear();
        else if (acc) model_beat(int'(ch), int'(a), int'(b));
        last_acc   = acc;
        acc_total += int'(acc);
        @(negedge clk);
    endtask

    task automatic beat(input int c, input int pa, input int pb);
        int k;
        in_valid = 1'b1;
        ch       = 1'(c);
        a        = 7'(pa);
        b        = 8'(pb);
        k        = 0;
        do begin
            tick();
            k++;
        end while (!last_acc && k < 50);
        if (!last_acc) check_val("beat_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while ((exp_q.size() != 0 || last_vld) && k < 40);
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; acc_total = 0;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ch = '0; a = '0; b = '0;
        model_clear();

        tick();
        check_val("rst_in_ready", int'(rdy17), 0);
        check_val("rst_out_valid", int'(vld17), 0);
        check_val("rst_out_ch", int'(ch17), 0);
        check_val("rst_flt_c", int'(c17), 0);
        check_val("rst_status", int'(st12), 0);
        rst_n = 1'b1;
        tick();
        tick();

        // 4 x (3*5) on ch0: result 60, visible two cycles after the last accept
        for (int i = 0; i < 4; i++) beat(0, 3, 5);
        in_valid = 1'b0;
        tick();
        check_val("lat_early", int'(last_vld), 0);
        tick();
        check_val("lat_valid", int'(last_vld), 1);
        drain("drain_basic");
        check_val("basic_status12", int'(last_st12), 0);

        // interleaved: ch0 -> 4, ch1 -> -80
        for (int i = 0; i < 4; i++) begin
            beat(0, 1, 1);
            beat(1, -2, 10);
        end
        drain("drain_interleave");

        // saturation: 4 x 8192 = 32768 clamps to 2047 at OUT_W=12
        for (int i = 0; i < 4; i++) beat(0, -64, -128);
        drain("drain_sat");
        check_val("sat_status_set", int'(last_st12), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check_val("clr_status", int'(last_st12), 0);

        // backpressure: three ch0 groups offered with out_ready low
        acc_total = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ch        = 1'b0;
        for (int i = 0; i < 24; i++) begin
            a = 7'($urandom);
            b = 8'($urandom);
            tick();
        end
        check_val("bp_accepts", acc_total, 8);
        check_val("bp_ready_low", int'(last_rdy), 0);
        check_val("bp_held", exp_q.size(), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && acc_total < 12; i++) begin
            a = 7'($urandom);
            b = 8'($urandom);
            tick();
        end
        check_val("bp_all_accepted", acc_total, 12);
        drain("drain_bp");

        // reset mid-accumulation drops the partial sum
        beat(0, 1, 2);
        beat(0, 1, 2);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_val("midrst_ready", int'(rdy17), 0);
        check_val("midrst_valid", int'(vld17), 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) beat(0, 1, 2);
        drain("drain_midrst");

        // en low stalls acceptance and holds partial sums
        beat(1, 3, 3);
        beat(1, 3, 3);
        en = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("en_low_ready", int'(last_rdy), 0);
        end
        en = 1'b1;
        beat(1, 3, 3);
        beat(1, 3, 3);
        drain("drain_en");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            ch        = 1'($urandom);
            a         = 7'($urandom);
            b         = 8'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 149) == 0);
            tick();
        end
        clr = 1'b0;
        en  = 1'b1;
        drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
